// File: rtl/ps2_char_decoder_pkg.sv
// Shared constants, scan-FSM states and the set-2 scan-code map for the
// PS/2 character decoder front end of the hangman datapath.
package ps2_pkg;

  localparam logic [4:0] CHAR_NONE  = 5'd0;
  localparam logic [4:0] CHAR_BKSP  = 5'd30;
  localparam logic [4:0] CHAR_ENTER = 5'd31;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EXT       = 2'd1,
    BREAK     = 2'd2,
    EXT_BREAK = 2'd3
  } scan_state_e;

  // Data bits plus parity bit must XOR to 1 for odd parity.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

  // Letters map to 1..26 (A..Z); Backspace/Enter to 30/31; anything else 0.
  function automatic logic [4:0] map_scancode(input logic [7:0] sc);
    logic [4:0] code;
    case (sc)
      8'h1C:   code = 5'd1;
      8'h32:   code = 5'd2;
      8'h21:   code = 5'd3;
      8'h23:   code = 5'd4;
      8'h24:   code = 5'd5;
      8'h2B:   code = 5'd6;
      8'h34:   code = 5'd7;
      8'h33:   code = 5'd8;
      8'h43:   code = 5'd9;
      8'h3B:   code = 5'd10;
      8'h42:   code = 5'd11;
      8'h4B:   code = 5'd12;
      8'h3A:   code = 5'd13;
      8'h31:   code = 5'd14;
      8'h44:   code = 5'd15;
      8'h4D:   code = 5'd16;
      8'h15:   code = 5'd17;
      8'h2D:   code = 5'd18;
      8'h1B:   code = 5'd19;
      8'h2C:   code = 5'd20;
      8'h3C:   code = 5'd21;
      8'h2A:   code = 5'd22;
      8'h1D:   code = 5'd23;
      8'h22:   code = 5'd24;
      8'h35:   code = 5'd25;
      8'h1A:   code = 5'd26;
      8'h66:   code = CHAR_BKSP;
      8'h5A:   code = CHAR_ENTER;
      default: code = CHAR_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ps2_char_decoder_frame_rx.sv
// PS/2 frame receiver: synchronises the pins, samples data on falling
// ps2_clk edges, checks start/parity/stop and abandons stalled frames.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_i,
  input  logic       resetn_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_bad_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [9:0]             shift_q, shift_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;
  logic [7:0]             byte_q, byte_d;
  logic                   byte_valid_q, byte_valid_d;
  logic                   frame_bad_q, frame_bad_d;
  logic                   clk_s, dat_s, fall_s, frame_good_s;

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  // Pin synchronisers; both lines idle high.
  always_ff @(posedge clk_i or posedge resetn_i) begin
    if (resetn_i) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
      clk_prev_q <= clk_s;
    end
  end

  assign fall_s = clk_prev_q & ~clk_s;
  // shift_q[0] = start, [8:1] = data LSB first, [9] = parity; stop is dat_s.
  assign frame_good_s = ~shift_q[0] & odd_parity_ok(shift_q[9:1]) & dat_s;

  // Bit counter, shift register, frame check and mid-frame timeout.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    to_cnt_d     = to_cnt_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    frame_bad_d  = 1'b0;
    if (fall_s) begin
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        if (frame_good_s) begin
          byte_valid_d = 1'b1;
          byte_d       = shift_q[8:1];
        end else begin
          frame_bad_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = {dat_s, shift_q[9:1]};
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TO_LAST) begin
        bit_cnt_d = 4'd0;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + {{(TW-1){1'b0}}, 1'b1};
      end
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  // Receiver state registers.
  always_ff @(posedge clk_i or posedge resetn_i) begin
    if (resetn_i) begin
      bit_cnt_q    <= 4'd0;
      shift_q      <= 10'd0;
      to_cnt_q     <= '0;
      byte_q       <= 8'd0;
      byte_valid_q <= 1'b0;
      frame_bad_q  <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      to_cnt_q     <= to_cnt_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      frame_bad_q  <= frame_bad_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_bad_o  = frame_bad_q;

endmodule

// File: rtl/ps2_char_decoder.sv
// PS/2 keyboard to 5-bit character decoder: scan FSM with break/extended
// handling, auto-repeat suppression, single-entry output and sticky errors.
module ps2_char_decoder
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       char_ack,
  input  logic       err_clr,
  output logic [4:0] char,
  output logic       char_valid,
  output logic       frame_err,
  output logic       overflow
);

  logic [7:0]  rx_byte_s;
  logic        rx_valid_s, rx_bad_s;
  scan_state_e state_q, state_d;
  logic [7:0]  last_make_q, last_make_d;
  logic [4:0]  code_s;
  logic        emit_s, ovf_set_s;
  logic [4:0]  char_q, char_d;
  logic        char_valid_q, char_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overflow_q, overflow_d;

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk_i       (clk),
    .resetn_i    (resetn),
    .ps2_clk_i   (ps2_clk),
    .ps2_dat_i   (ps2_dat),
    .byte_o      (rx_byte_s),
    .byte_valid_o(rx_valid_s),
    .frame_bad_o (rx_bad_s)
  );

  assign code_s = map_scancode(rx_byte_s);

  // Scan FSM next state, auto-repeat tracking and emit decision.
  always_comb begin
    state_d     = state_q;
    last_make_d = last_make_q;
    emit_s      = 1'b0;
    if (rx_valid_s) begin
      case (state_q)
        IDLE: begin
          if (rx_byte_s == SC_EXT) begin
            state_d = EXT;
          end else if (rx_byte_s == SC_BREAK) begin
            state_d = BREAK;
          end else if ((code_s != CHAR_NONE) && (rx_byte_s != last_make_q)) begin
            emit_s      = 1'b1;
            last_make_d = rx_byte_s;
          end else begin
            state_d = IDLE;
          end
        end
        EXT: begin
          state_d = (rx_byte_s == SC_BREAK) ? EXT_BREAK : IDLE;
        end
        BREAK: begin
          state_d = IDLE;
          // Releasing the held key re-arms it for the next press.
          if (rx_byte_s == last_make_q) begin
            last_make_d = 8'h00;
          end else begin
            last_make_d = last_make_q;
          end
        end
        EXT_BREAK: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output register handshake and sticky flags (set beats clear).
  always_comb begin
    char_d       = char_q;
    char_valid_d = char_valid_q;
    ovf_set_s    = 1'b0;
    if (emit_s) begin
      if (!char_valid_q || char_ack) begin
        char_d       = code_s;
        char_valid_d = 1'b1;
      end else begin
        ovf_set_s = 1'b1;
      end
    end else if (char_valid_q && char_ack) begin
      char_valid_d = 1'b0;
    end else begin
      char_valid_d = char_valid_q;
    end
    if (ovf_set_s) begin
      overflow_d = 1'b1;
    end else if (err_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (rx_bad_s) begin
      frame_err_d = 1'b1;
    end else if (err_clr) begin
      frame_err_d = 1'b0;
    end else begin
      frame_err_d = frame_err_q;
    end
  end

  // Decoder state and output registers.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q      <= IDLE;
      last_make_q  <= 8'h00;
      char_q       <= CHAR_NONE;
      char_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_make_q  <= last_make_d;
      char_q       <= char_d;
      char_valid_q <= char_valid_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
    end
  end

  assign char       = char_q;
  assign char_valid = char_valid_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_char_decoder.sv
// Self-checking bench for ps2_char_decoder: directed scenarios plus random
// key traffic compared against a queue-free behavioural keyboard model.
module tb_ps2_char_decoder;

  localparam int TO = 64;
  localparam int H  = 6;

  logic       clk      = 1'b0;
  logic       resetn   = 1'b1;
  logic       ps2_clk  = 1'b1;
  logic       ps2_dat  = 1'b1;
  logic       char_ack = 1'b0;
  logic       err_clr  = 1'b0;
  logic [4:0] char;
  logic       char_valid, frame_err, overflow;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  logic [4:0] m_char;
  logic       m_valid, m_ovf, m_err, m_e0, m_f0;
  logic [7:0] m_last;

  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  always #5 clk = ~clk;

  ps2_char_decoder #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .char_ack  (char_ack),
    .err_clr   (err_clr),
    .char      (char),
    .char_valid(char_valid),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ref_map(input logic [7:0] b);
    for (int i = 0; i < 26; i++)
      if (letter_sc[i] == b) return 5'(i + 1);
    if (b == 8'h66) return 5'd30;
    if (b == 8'h5A) return 5'd31;
    return 5'd0;
  endfunction

  task automatic model_reset();
    m_char = 5'd0; m_valid = 1'b0; m_ovf = 1'b0; m_err = 1'b0;
    m_e0 = 1'b0; m_f0 = 1'b0; m_last = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit bad);
    logic [4:0] code;
    if (bad) begin
      m_err = 1'b1;
    end else if (m_f0) begin
      if (!m_e0 && b == m_last) m_last = 8'h00;
      m_e0 = 1'b0; m_f0 = 1'b0;
    end else if (m_e0) begin
      if (b == 8'hF0) m_f0 = 1'b1;
      else m_e0 = 1'b0;
    end else if (b == 8'hE0) begin
      m_e0 = 1'b1;
    end else if (b == 8'hF0) begin
      m_f0 = 1'b1;
    end else begin
      code = ref_map(b);
      if (code != 5'd0 && b != m_last) begin
        m_last = b;
        if (!m_valid) begin
          m_char = code; m_valid = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".char"}, 8'(char), 8'(m_char));
    check({tag, ".valid"}, 8'(char_valid), 8'(m_valid));
    check({tag, ".ovf"}, 8'(overflow), 8'(m_ovf));
    check({tag, ".ferr"}, 8'(frame_err), 8'(m_err));
  endtask

  task automatic ps2_bit(input logic v, input bit watch);
    int n;
    ps2_dat = v;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    n = 0;
    while (n < H) begin
      @(negedge clk);
      n++;
      if (watch && dut.u_rx.byte_valid_o === 1'b1) begin
        check("lat_pre_valid", 8'(char_valid), 8'd0);
        @(negedge clk);
        n++;
        check("lat_post_valid", 8'(char_valid), 8'd1);
      end
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input bit watch);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i], watch && (i == 10));
    ps2_dat = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit bad, input string tag);
    send_frame(b, bad, 11, 1'b0);
    model_byte(b, bad);
    compare_all(tag);
  endtask

  task automatic ack();
    char_ack = 1'b1;
    @(negedge clk);
    char_ack = 1'b0;
    m_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_ovf = 1'b0; m_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int emits;
    logic [7:0] b;
    int r;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all("reset");
    resetn = 1'b0;
    repeat (2) @(negedge clk);

    // Press A with latency watch, then release it.
    send_frame(8'h1C, 1'b0, 11, 1'b1);
    model_byte(8'h1C, 1'b0);
    compare_all("a_make");
    check("a_char", 8'(char), 8'd1);
    send(8'hF0, 1'b0, "a_brk0");
    send(8'h1C, 1'b0, "a_brk1");
    check("a_no_ovf", 8'(overflow), 8'd0);
    check("a_last_clear", dut.last_make_q, 8'h00);
    ack();

    // Typematic repeat, release, press again.
    emits = 0;
    for (int i = 0; i < 3; i++) begin
      send(8'h1C, 1'b0, "rep");
      if (char_valid) emits++;
      ack();
    end
    send(8'hF0, 1'b0, "rep_brk0");
    send(8'h1C, 1'b0, "rep_brk1");
    if (char_valid) emits++;
    ack();
    send(8'h1C, 1'b0, "rep_again");
    if (char_valid) emits++;
    check("rep_char", 8'(char), 8'd1);
    ack();
    check("rep_emits", 8'(emits), 8'd2);

    // Overflow while E is pending.
    send(8'h24, 1'b0, "ovf_e");
    send(8'h2D, 1'b0, "ovf_r");
    check("ovf_flag", 8'(overflow), 8'd1);
    check("ovf_char", 8'(char), 8'd5);
    clr();
    compare_all("ovf_clr");
    ack();

    // Parity error then good Enter.
    send(8'h5A, 1'b1, "par_bad");
    check("par_ferr", 8'(frame_err), 8'd1);
    send(8'h5A, 1'b0, "par_good");
    check("par_char", 8'(char), 8'd31);
    ack();
    clr();

    // Extended keypad Enter ignored; Backspace accepted.
    send(8'hE0, 1'b0, "ext0");
    send(8'h5A, 1'b0, "ext1");
    send(8'hE0, 1'b0, "ext2");
    send(8'hF0, 1'b0, "ext3");
    send(8'h5A, 1'b0, "ext4");
    check("ext_idle", 8'(dut.state_q), 8'(ps2_pkg::IDLE));
    send(8'h66, 1'b0, "bksp");
    check("bksp_char", 8'(char), 8'd30);
    ack();

    // Stalled partial frame is discarded silently.
    send_frame(8'h35, 1'b0, 4, 1'b0);
    repeat (TO + 10) @(negedge clk);
    check("to_ferr", 8'(frame_err), 8'd0);
    check("to_valid", 8'(char_valid), 8'd0);
    send(8'h35, 1'b0, "to_y");
    check("to_char", 8'(char), 8'd25);
    send(8'h00, 1'b1, "pre_rst_bad");
    send(8'h1C, 1'b0, "pre_rst_ovf");

    // Reset in the middle of a frame.
    send_frame(8'h44, 1'b0, 5, 1'b0);
    resetn = 1'b1;
    @(negedge clk);
    model_reset();
    compare_all("mid_rst");
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    send(8'h44, 1'b0, "post_rst");
    check("post_rst_char", 8'(char), 8'd15);
    ack();

    // Random traffic against the model.
    for (int k = 0; k < 120; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: b = 8'hF0;
        1: b = 8'hE0;
        2: b = 8'h66;
        3: b = 8'h5A;
        4: b = 8'($urandom_range(0, 255));
        5, 6: b = letter_sc[$urandom_range(0, 3)];
        default: b = letter_sc[$urandom_range(0, 25)];
      endcase
      send(b, $urandom_range(0, 15) == 0, "rnd");
      if ($urandom_range(0, 1) == 0) ack();
      if ($urandom_range(0, 7) == 0) clr();
    end
    compare_all("final");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
